// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB register-file completer.
package apb_slv_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int ADDR_LSB = 2;
  localparam int DATA_W   = 32;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0]   old_val,
    input logic [DATA_W-1:0]   new_val,
    input logic [DATA_W/8-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_slv_regbank.sv
// Register array with a byte-strobed write port and a combinational read port;
// index 0 is the constant ID register and is never written.
module apb_slv_regbank
  import apb_slv_pkg::*;
#(
  parameter int              NUM_REGS = 8,
  parameter logic [DATA_W-1:0] ID_VALUE = 32'hA9B0_0001,
  parameter int              IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                pclk,
  input  logic                prst,
  input  logic                we,
  input  logic [IDX_W-1:0]    widx,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [IDX_W-1:0]    ridx,
  output logic [DATA_W-1:0]   rdata
);

  localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d    = regs_q;
    regs_d[0] = '0;
    if (we && (widx != '0) && ({1'b0, widx} < NREGS)) begin
      regs_d[widx] = strb_merge(regs_q[widx], wdata, wstrb);
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) regs_q <= '{default: '0};
    else      regs_q <= regs_d;
  end

  always_comb begin
    rdata = '0;
    if (ridx == '0)                   rdata = ID_VALUE;
    else if ({1'b0, ridx} < NREGS)    rdata = regs_q[ridx];
  end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a register bank, programmable wait states and pslverr decode.
// Define APB_SLV_RO_ERR_EN to flag writes to the read-only ID register with pslverr.
module apb_slave_regfile
  import apb_slv_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001,
  parameter int          STRB_W      = 4
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       paddr,
  input  logic [31:0]       pwdata,
  input  logic [STRB_W-1:0] pstrb,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = $clog2(NUM_REGS);

`ifdef APB_SLV_RO_ERR_EN
  localparam logic RO_ERR = 1'b1;
`else
  localparam logic RO_ERR = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic              ro_q, ro_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q, strb_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic [31:0]       word_off;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_err;
  logic              we;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    word_off = (paddr - BASE_ADDR) >> ADDR_LSB;
    dec_idx  = word_off[IDX_W-1:0];
    dec_err  = (paddr < BASE_ADDR) || (word_off >= NUM_REGS) ||
               (paddr[ADDR_LSB-1:0] != '0);
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      ro_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      ro_q    <= ro_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
    end
  end

  // Only a setup phase (psel without penable) starts a transfer from IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    ro_d    = ro_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          wr_d    = pwrite;
          err_d   = dec_err;
          ro_d    = pwrite && !dec_err && (dec_idx == '0);
          idx_d   = dec_idx;
          wdata_d = pwdata;
          strb_d  = pstrb;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // idx_d/wr_d/err_d hold the live decode on a zero-wait setup and the latched one otherwise.
  always_comb begin
    pready_d  = (state_d == RESP);
    pslverr_d = (pready_d && (err_d || (RO_ERR && ro_d))) ? RESP_ERR : RESP_OKAY;
    prdata_d  = (pready_d && !wr_d && !err_d) ? rdata : '0;
    we        = (state_q == RESP) && wr_q && !err_q;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign prdata  = prdata_q;

  apb_slv_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .pclk  (pclk),
    .prst  (prst),
    .we    (we),
    .widx  (idx_q),
    .wdata (wdata_q),
    .wstrb (strb_q),
    .ridx  (idx_d),
    .rdata (rdata)
  );

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- Synthesizable APB completer (slave) with a bank of 32-bit registers, register 0 read-only ID.
- Responder counterpart to the agent's master driver; sits behind one APB psel line as the DUT/reference target for the UVC.
- Supports programmable wait states, pstrb byte-lane writes, and pslverr on bad addresses.

Parameters:
- NUM_REGS, 8, number of 32-bit registers including ID register (>=2).
- BASE_ADDR, 32'h0000_0000, byte address of register 0.
- WAIT_STATES, 0, access cycles with pready low before completion (0..15).
- ID_VALUE, 32'hA9B0_0001, constant read value of register 0.
- STRB_W, 4, pstrb width, equal to data bytes.

Ports:
- pclk, input, 1, clock.
- prst, input, 1, synchronous active-high reset.
- psel, input, 1, select for this completer.
- penable, input, 1, access phase.
- pwrite, input, 1, 1 = write.
- paddr, input, 32, byte address.
- pwdata, input, 32, write data.
- pstrb, input, STRB_W, write byte enables.
- prdata, output, 32, read data.
- pready, output, 1, transfer complete.
- pslverr, output, 1, error response.

Behaviour:
- Interface: one clock, pclk. Reset prst is synchronous and active-high.
- Reset values: pready=0, prdata=0, pslverr=0, FSM=IDLE, counter=0, regs 1..NUM_REGS-1 = 0.
- Outputs are registered.
- FSM IDLE:
  - psel=1 & penable=0 (setup) latches paddr, pwrite, pwdata, pstrb and decodes the address.
  - If WAIT_STATES==0, go to RESP. Otherwise load cnt=WAIT_STATES and go to WAIT.
  - penable=1 without a prior setup is ignored.
- FSM WAIT: pready=0. cnt decrements each cycle. At cnt==1, go to RESP.
  - psel=0 while in WAIT is an abort: go to IDLE, no write, no response.
- FSM RESP: pready=1 for exactly one cycle, then IDLE.
  - Result: pready high in access cycle WAIT_STATES+1.
  - WAIT_STATES=0 gives a zero-wait APB transfer: setup cycle, then access cycle with pready=1.
- Read path: prdata = selected register, captured on entry to RESP. prdata=0 in all other cycles and on error.
- Write path:
  - Commit on the edge ending the RESP cycle.
  - For each byte b with pstrb[b]=1: reg[idx][8b+7:8b] = pwdata byte. Bytes with pstrb[b]=0 are unchanged.
  - pstrb=0 is a legal no-op with an OKAY response.
- Decode: idx = (paddr-BASE_ADDR)>>2.
  - Error if paddr<BASE_ADDR, idx>=NUM_REGS, or paddr[1:0]!=0.
  - Error gives pslverr=1 in RESP, no write, prdata=0.
  - pslverr=0 in all other cycles.
- ID register: reads return ID_VALUE. Writes never modify it (response per Optional Feature).
- Back-to-back: a setup in the cycle right after RESP is accepted from IDLE. No dead cycle is required beyond APB's own.
- Reset mid-transfer: prst wins in any state. Pending write is discarded, outputs return to reset values next cycle.
- pstrb is ignored on reads.

Optional Feature:
- Macro: APB_SLV_RO_ERR_EN.
- Defined: a write to the ID register completes with pslverr=1 in RESP.
- Undefined: the write is silently dropped with pslverr=0.
- Register contents are identical in both builds.

Decomposition:
- Package apb_slv_pkg:
  - state enum (IDLE, WAIT, RESP).
  - ADDR_LSB=2, DATA_W=32.
  - Response constants RESP_OKAY=1'b0, RESP_ERR=1'b1.
  - Function for strobe-masked merge.
- Sub-module apb_slv_regbank:
  - Register array with byte-strobe write port and combinational read port.
  - Contains the ID register mux.
  - FSM/decoder stays in top.

Test Plan (NUM_REGS=8, BASE_ADDR=0, ID_VALUE=32'hA9B0_0001):
1. Reset, then read 0x00 with WAIT_STATES=0 -> pready=1 in first access cycle, prdata=32'hA9B0_0001, pslverr=0.
2. Write 0x04 data 32'h1122_3344 strb 4'hF, then write 0x04 data 32'hFFFF_FFFF strb 4'b0101, then read 0x04 -> prdata=32'h11FF_33FF.
3. WAIT_STATES=3, write then read 0x08 -> pready low for 3 access cycles, high on the 4th; read returns written data.
4. Read 0x20 (idx 8) and read 0x06 (unaligned) -> pslverr=1, prdata=0. A following write to 0x20 leaves all regs unchanged.
5. Write 0x00 data 32'h0 -> with APB_SLV_RO_ERR_EN: pslverr=1; without: pslverr=0. Both builds: read back 32'hA9B0_0001.
6. WAIT_STATES=3, write 0x0C, assert prst during 2nd WAIT cycle -> pready=0 next cycle, read 0x0C returns 0. Then drop psel mid-WAIT on a write -> no write, FSM in IDLE.
